// File: rtl/logit_argmax_pkg.sv
// Result-word layout shared by the argmax stage and the host-side decoder.
package logit_argmax_pkg;

  localparam int unsigned RES_W        = 32;
  localparam int unsigned RES_MARK_BIT = 31;
  localparam int unsigned RES_ERR_BIT  = 30;
  localparam int unsigned RES_IDX_LSB  = 24;
  localparam int unsigned RES_IDX_W    = 4;
  localparam int unsigned RES_VAL_W    = 24;

  // Bits [29:28] stay zero; value is expected already sign-extended to RES_VAL_W.
  function automatic logic [RES_W-1:0] pack_result(
    input logic                 err,
    input logic [RES_IDX_W-1:0] idx,
    input logic [RES_VAL_W-1:0] value
  );
    logic [RES_W-1:0] r;
    r                           = '0;
    r[RES_MARK_BIT]             = 1'b1;
    r[RES_ERR_BIT]              = err;
    r[RES_IDX_LSB +: RES_IDX_W] = idx;
    r[RES_VAL_W-1:0]            = value;
    return r;
  endfunction

endpackage

// File: rtl/logit_argmax.sv
// Streaming argmax over one frame of N signed logits; emits one packed result word per frame.
module logit_argmax
  import logit_argmax_pkg::*;
#(
  parameter int unsigned N         = 10,
  parameter int unsigned DATA_BITS = 18,
  parameter int unsigned WORD_SIZE = 29,
  parameter bit          USE_LAST  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  output logic [RES_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned          IDX_BITS = $clog2(N);
  localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(N - 1);

  logic [IDX_BITS-1:0]         idx_q;
  logic [IDX_BITS-1:0]         max_idx_q;
  logic [IDX_BITS-1:0]         max_idx_d;
  logic signed [DATA_BITS-1:0] max_q;
  logic signed [DATA_BITS-1:0] max_d;
  logic signed [DATA_BITS-1:0] v;
  logic                        beat;
  logic                        at_last;
  logic                        frame_end;
  logic                        err_d;
  logic                        unused_upper;

  assign v            = in_data[DATA_BITS-1:0];
  assign unused_upper = ^in_data;

  // Single result register: accept whenever it is empty or draining this cycle.
  assign in_ready  = reset || !out_valid || out_ready;
  assign beat      = in_valid && in_ready;
  assign at_last   = (idx_q == LAST_IDX);
  assign frame_end = beat && (at_last || (USE_LAST && in_last));
  assign err_d     = USE_LAST && (in_last != at_last);

  // Running max including the current word; strict compare keeps the lower index on ties.
  always_comb begin
    max_d     = max_q;
    max_idx_d = max_idx_q;
    if (idx_q == '0) begin
      max_d     = v;
      max_idx_d = '0;
    end else if (v > max_q) begin
      max_d     = v;
      max_idx_d = idx_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (beat) begin
        max_q     <= max_d;
        max_idx_q <= max_idx_d;
        idx_q     <= frame_end ? '0 : idx_q + 1'b1;
      end
      if (frame_end) begin
        out_valid <= 1'b1;
        out_data  <= pack_result(err_d, RES_IDX_W'(max_idx_d), RES_VAL_W'(max_d));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logit_argmax.sv
// Directed scoreboard bench for logit_argmax (N=10, DATA_BITS=18, WORD_SIZE=29).
module tb_logit_argmax;

  logic        clock;
  logic        reset;
  logic [28:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic        in_valid1;
  logic        in_ready1;
  logic [31:0] out_data1;
  logic        out_valid1;
  logic        out_ready1;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [31:0] sb [$];

  logic [28:0] fa   [10];
  logic [28:0] fm1  [10];
  logic [28:0] fneg [10];
  logic [28:0] fe   [10];
  logic [28:0] f5   [10];

  logit_argmax #(.N(10), .DATA_BITS(18), .WORD_SIZE(29), .USE_LAST(1'b1)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  logit_argmax #(.N(10), .DATA_BITS(18), .WORD_SIZE(29), .USE_LAST(1'b0)) dut_nolast (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid1),
    .in_ready(in_ready1), .in_last(in_last), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drain side of the scoreboard: every output beat pops one expected word.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else check("out_data", out_data, sb.pop_front());
    end
  end

  task automatic send(input logic [28:0] d, input logic l);
    int unsigned n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [28:0] w [10], input int n, input int last_at,
                            input logic [31:0] exp, input logic upper);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) sb.push_back(exp);
      send(upper ? (w[i] | 29'h1FFC0000) : w[i], i == last_at);
    end
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("latency_data", out_data, exp);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    fa   = '{29'h3, 29'h3FFFB, 29'h7, 29'h7, 29'h2, 29'h0, 29'h1, 29'h3FFFF, 29'h6, 29'h4};
    fm1  = '{default: 29'h3FFFF};
    fneg = '{29'h20000, 29'h20000, 29'h20000, 29'h20000, 29'h20000,
             29'h20000, 29'h20000, 29'h20000, 29'h20000, 29'h00001};
    fe   = '{29'h1, 29'h9, 29'h2, 29'h3, 29'h4, 29'h0, 29'h0, 29'h0, 29'h0, 29'h0};
    f5   = '{default: 29'h5};

    reset      = 1'b1;
    in_valid   = 1'b1;
    in_data    = 29'h7;
    in_last    = 1'b1;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    @(posedge clock);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic frame, then tie-at-index-0 and last-word-wins frames back to back.
    send_frame(fa, 10, 9, 32'h82000007, 1'b0);
    idle(2);
    send_frame(fm1, 10, 9, 32'h80FFFFFF, 1'b0);
    send_frame(fneg, 10, 9, 32'h89000001, 1'b0);
    idle(2);

    // Backpressure across two frames.
    out_ready = 1'b0;
    send_frame(fa, 10, 9, 32'h82000007, 1'b0);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    fork
      send_frame(fm1, 10, 9, 32'h80FFFFFF, 1'b0);
      begin
        repeat (4) @(posedge clock);
        #2;
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_data", out_data, 32'h82000007);
        check("bp_stall", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
    join
    idle(2);

    // Early in_last, then a full frame starting again at index 0.
    send_frame(fe, 5, 4, 32'hC1000009, 1'b0);
    send_frame(fa, 10, 9, 32'h82000007, 1'b0);
    idle(2);

    // Missing in_last: flagged with USE_LAST=1, clean with USE_LAST=0.
    send_frame(f5, 10, 10, 32'hC0000005, 1'b0);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      in_data   = 29'h5;
      in_last   = 1'b0;
      in_valid1 = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid1 = 1'b0;
    check("nolast_valid", {31'd0, out_valid1}, 32'd1);
    check("nolast_data", out_data1, 32'h80000005);
    idle(2);

    // Mid-frame reset drops the partial frame; upper word bits are ignored.
    for (int i = 0; i < 5; i++) send(29'h100, 1'b0);
    reset   = 1'b1;
    in_data = 29'h3FF;
    in_last = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    in_last = 1'b0;
    check("post_reset_valid", {31'd0, out_valid}, 32'd0);
    send_frame(fa, 10, 9, 32'h82000007, 1'b1);
    idle(2);

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clock);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("out_count", 32'(n_out), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
